// File: rtl/rr_grant_pkg.sv
// ---------------------------------------------------------------------------
// rr_grant_pkg
// Shared types and helpers for the round-robin grant controller.
//   state_e  : controller state (IDLE = no holder, GRANT = resource owned)
//   wrap_inc : priority-pointer advance with wrap at the requester count
// ---------------------------------------------------------------------------
package rr_grant_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Next pointer position after a holder releases: one past the holder,
    // wrapping back to requester 0 after the last requester.
    function automatic int unsigned wrap_inc(input int unsigned idx,
                                             input int unsigned num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// ---------------------------------------------------------------------------
// priority_encoder
// Lowest-index-first priority encoder.
//   id_vec   : input request vector
//   od_valid : at least one bit of id_vec is set
//   od_filt  : one-hot copy of the lowest set bit (zero when none)
//   od_bin   : binary index of the lowest set bit (zero when none)
// ---------------------------------------------------------------------------
module priority_encoder #(
    parameter int WIDTH   = 8,
    parameter int WIDTH_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   id_vec,
    output logic               od_valid,
    output logic [WIDTH-1:0]   od_filt,
    output logic [WIDTH_W-1:0] od_bin
);

    always_comb begin
        od_valid = |id_vec;
        od_filt  = '0;
        od_bin   = '0;
        // Scan from the top down so the lowest set bit is the last writer.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (id_vec[i]) begin
                od_filt    = '0;
                od_filt[i] = 1'b1;
                od_bin     = WIDTH_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// ---------------------------------------------------------------------------
// rr_grant_ctrl
// Round-robin grant controller sharing one downstream resource among
// NUM_REQ requesters. A grant is held until the holder raises done or the
// hold limit MAX_HOLD is reached; priority then rotates past the holder and
// the next winner (if any) is granted on the same edge.
//   clk        : clock, rising-edge active
//   reset_n    : asynchronous active-low reset
//   req        : level request vector, bit i = requester i
//   done       : holder finished (only looked at while a grant is active)
//   gnt_valid  : a grant is active
//   gnt_onehot : one-hot grant, zero when idle
//   gnt_idx    : binary index of holder, zero when idle
//   timeout    : one-cycle pulse after a forced revoke
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int NUM_REQ   = 8,
    parameter int NUM_REQ_W = $clog2(NUM_REQ),
    parameter int MAX_HOLD  = 16,
    parameter int HOLD_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic                 gnt_valid,
    output logic [NUM_REQ-1:0]   gnt_onehot,
    output logic [NUM_REQ_W-1:0] gnt_idx,
    output logic                 timeout
);

    state_e               state_q, state_d;
    logic [NUM_REQ_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 gnt_valid_q, gnt_valid_d;
    logic [NUM_REQ-1:0]   gnt_onehot_q, gnt_onehot_d;
    logic [NUM_REQ_W-1:0] gnt_idx_q, gnt_idx_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ_W-1:0] rot_ptr;
    logic [NUM_REQ_W-1:0] arb_ptr;
    logic [NUM_REQ-1:0]   keep_mask;
    logic [NUM_REQ-1:0]   masked;
    logic                 m_valid, a_valid;
    logic [NUM_REQ-1:0]   m_filt, a_filt;
    logic [NUM_REQ_W-1:0] m_bin, a_bin;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [NUM_REQ_W-1:0] win_idx;
    logic                 at_max;
    logic                 release_evt;

    // Pointer the holder would leave behind on release.
    assign rot_ptr = NUM_REQ_W'(wrap_inc(32'(gnt_idx_q), NUM_REQ));

    // While granted, arbitration is only consumed on release, and then it
    // must already see the rotated pointer. This depends on gnt_idx_q only,
    // so done never reaches the arbiter.
    assign arb_ptr = (state_q == GRANT) ? rot_ptr : ptr_q;

    // Keep requesters at or above the pointer: req & ~((1<<ptr)-1).
    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            keep_mask[i] = (32'(i) >= 32'(arb_ptr));
        end
    end

    assign masked = req & keep_mask;

    priority_encoder #(
        .WIDTH   (NUM_REQ),
        .WIDTH_W (NUM_REQ_W)
    ) u_pe_masked (
        .id_vec   (masked),
        .od_valid (m_valid),
        .od_filt  (m_filt),
        .od_bin   (m_bin)
    );

    priority_encoder #(
        .WIDTH   (NUM_REQ),
        .WIDTH_W (NUM_REQ_W)
    ) u_pe_all (
        .id_vec   (req),
        .od_valid (a_valid),
        .od_filt  (a_filt),
        .od_bin   (a_bin)
    );

    // Nothing at or above the pointer: wrap to the lowest requester overall.
    assign win_onehot = m_valid ? m_filt : a_filt;
    assign win_idx    = m_valid ? m_bin  : a_bin;

    assign at_max      = (hold_cnt_q == HOLD_W'(MAX_HOLD));
    assign release_evt = done || at_max;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_onehot_d = gnt_onehot_q;
        gnt_idx_d    = gnt_idx_q;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_valid) begin
                    state_d      = GRANT;
                    gnt_valid_d  = 1'b1;
                    gnt_onehot_d = win_onehot;
                    gnt_idx_d    = win_idx;
                    hold_cnt_d   = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (release_evt) begin
                    ptr_d     = rot_ptr;
                    // A done on the limit cycle counts as a normal release.
                    timeout_d = !done;
                    if (a_valid) begin
                        gnt_onehot_d = win_onehot;
                        gnt_idx_d    = win_idx;
                        hold_cnt_d   = HOLD_W'(1);
                    end else begin
                        state_d      = IDLE;
                        gnt_valid_d  = 1'b0;
                        gnt_onehot_d = '0;
                        gnt_idx_d    = '0;
                        hold_cnt_d   = '0;
                    end
                end else begin
                    // The limit value always releases, so this never wraps.
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= '0;
            gnt_idx_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_onehot_q <= gnt_onehot_d;
            gnt_idx_q    <= gnt_idx_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_onehot = gnt_onehot_q;
    assign gnt_idx    = gnt_idx_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_ctrl
// Self-checking bench for rr_grant_ctrl (NUM_REQ=8, MAX_HOLD=16).
// ---------------------------------------------------------------------------
module tb_rr_grant_ctrl;

    localparam int N    = 8;
    localparam int MAXH = 16;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] req;
    logic         done;
    logic         gnt_valid;
    logic [N-1:0] gnt_onehot;
    logic [2:0]   gnt_idx;
    logic         timeout;

    int n_checks;
    int n_pass;

    rr_grant_ctrl #(
        .NUM_REQ   (N),
        .NUM_REQ_W (3),
        .MAX_HOLD  (MAXH),
        .HOLD_W    (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .done       (done),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic         exp_v;
        logic [2:0]   exp_idx;
        logic         exp_to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [N-1:0] r, logic d, logic v,
                                logic [2:0] idx, logic to);
        vec_t x;
        x.req = r; x.done = d; x.exp_v = v; x.exp_idx = idx; x.exp_to = to;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input logic ev,
                             input logic [2:0] eidx, input logic eto);
        logic [N-1:0] eoh;
        eoh = ev ? (N'(1) << eidx) : '0;
        check({tag, ".valid"},  32'(gnt_valid),  32'(ev));
        check({tag, ".idx"},    32'(gnt_idx),    ev ? 32'(eidx) : 32'd0);
        check({tag, ".onehot"}, 32'(gnt_onehot), 32'(eoh));
        check({tag, ".timeout"}, 32'(timeout),   32'(eto));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Grant = first requester found scanning upward from ptr, circularly.
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_hold;
    bit m_to;

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        int w;
        m_to = 0;
        if (!m_valid) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1; m_idx = w; m_hold = 1;
            end
        end else if (d || m_hold == MAXH) begin
            m_to  = !d;
            m_ptr = (m_idx + 1) % N;
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_idx = w; m_hold = 1;
            end else begin
                m_valid = 0; m_idx = 0; m_hold = 0;
            end
        end else begin
            m_hold++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        req      = 8'hFF;
        done     = 1'b0;

        // Reset held with all requests active: nothing may be granted.
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_hold", 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        req = '0;
        reset_n = 1'b1;

        // Single request, holder drops req, done on third grant cycle.
        do_reset();
        req = 8'h01;
        tick(); check_out("single_c1", 1'b1, 3'd0, 1'b0);
        req = 8'h00;
        tick(); check_out("single_c2", 1'b1, 3'd0, 1'b0);
        tick(); check_out("single_c3", 1'b1, 3'd0, 1'b0);
        done = 1'b1;
        tick(); check_out("single_rel", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        req  = 8'h03;   // ptr=1 must favour requester 1 over 0
        tick(); check_out("single_ptr1", 1'b1, 3'd1, 1'b0);

        // Table: rotation over all requesters, then a two-requester subset.
        do_reset();
        for (int i = 0; i < N; i++) tbl.push_back(mk(8'hFF, 1'b1, 1'b1, 3'(i), 1'b0));
        tbl.push_back(mk(8'hFF, 1'b1, 1'b1, 3'd0, 1'b0));
        tbl.push_back(mk(8'h0C, 1'b1, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(8'h0C, 1'b1, 1'b1, 3'd3, 1'b0));
        tbl.push_back(mk(8'h0C, 1'b1, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(8'h0C, 1'b1, 1'b1, 3'd3, 1'b0));
        tbl.push_back(mk(8'h00, 1'b1, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 1'b0));
        tbl.push_back(mk(8'h0C, 1'b0, 1'b1, 3'd2, 1'b0));
        tbl.push_back(mk(8'h0C, 1'b0, 1'b1, 3'd2, 1'b0));
        for (int k = 0; k < tbl.size(); k++) begin
            req  = tbl[k].req;
            done = tbl[k].done;
            tick();
            check_out($sformatf("tbl%0d", k), tbl[k].exp_v, tbl[k].exp_idx, tbl[k].exp_to);
        end

        // Forced revoke after exactly MAXH cycles.
        do_reset();
        req = 8'h10;
        tick(); check_out("to_c1", 1'b1, 3'd4, 1'b0);
        req = 8'h00;
        for (int c = 2; c <= MAXH; c++) begin
            tick(); check_out($sformatf("to_c%0d", c), 1'b1, 3'd4, 1'b0);
        end
        tick(); check_out("to_revoke", 1'b0, 3'd0, 1'b1);
        // ptr=5: nothing at or above it in 0x11, so wrap to requester 0.
        req = 8'h11;
        tick(); check_out("to_wrap", 1'b1, 3'd0, 1'b0);
        req = 8'h00;
        for (int c = 2; c <= MAXH; c++) tick();
        check_out("lim_c16", 1'b1, 3'd0, 1'b0);
        done = 1'b1;    // done on the limit cycle: normal release
        tick(); check_out("lim_done", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        tick(); check_out("lim_after", 1'b0, 3'd0, 1'b0);

        // Reset mid-grant with a non-zero pointer.
        do_reset();
        req = 8'h04;
        tick(); check_out("mid_g2", 1'b1, 3'd2, 1'b0);
        req = 8'h08; done = 1'b1;
        tick(); check_out("mid_g3", 1'b1, 3'd3, 1'b0);
        done = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check_out("mid_async", 1'b0, 3'd0, 1'b0);
        req = 8'h0A;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick(); check_out("mid_ptr0", 1'b1, 3'd1, 1'b0);

        // Randomised run against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int r;
            bit slow;
            slow = ((cyc / 200) % 2) == 1;
            r = $urandom_range(0, 3);
            if (r == 0)      req = '0;
            else if (r == 1) req = N'(1) << $urandom_range(0, N - 1);
            else             req = N'($urandom);
            done = slow ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 9) < 3);
            tick();
            model_step(req, done);
            check_out($sformatf("rnd%0d", cyc), m_valid, 3'(m_idx), m_to);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin grant controller that shares one downstream resource among NUM_REQ requesters. Each cycle it picks one winner from a request vector using a rotating-priority mask. It holds the grant until the winner signals completion or a hold-timeout expires, then moves priority past the last winner. It sits between the requester bank and the shared resource and drives the resource's select/enable.

## Interface
- NUM_REQ, 8: number of requesters; must be ≥ 2.
- NUM_REQ_W, $clog2(NUM_REQ): index width.
- MAX_HOLD, 16: maximum grant cycles before forced revoke; must be ≥ 1.
- HOLD_W, $clog2(MAX_HOLD+1): hold-counter width.

- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- req, input, NUM_REQ: level requests; bit i = requester i wants the resource.
- done, input, 1: current grant holder finished; sampled only while gnt_valid=1.
- gnt_valid, output, 1: a grant is active.
- gnt_onehot, output, NUM_REQ: one-hot grant; all zeros when gnt_valid=0.
- gnt_idx, output, NUM_REQ_W: binary index of the holder; 0 when gnt_valid=0.
- timeout, output, 1: one-cycle pulse when a grant is force-revoked.

## Operation
- State: IDLE or GRANT. Also registers ptr (NUM_REQ_W), hold_cnt (HOLD_W), and the grant outputs.
- Arbitration (combinational):
  - masked = req & ~((1<<ptr)-1).
  - If masked≠0, the winner is the lowest set index of masked.
  - Otherwise, the winner is the lowest set index of req.
  - any = |req.
- IDLE:
  - any=1: load the winner into gnt_onehot/gnt_idx, set gnt_valid=1, hold_cnt=1, go to GRANT.
  - any=0: stay in IDLE.
  - done is ignored.
- GRANT, in priority order:
  - done=1, or hold_cnt==MAX_HOLD:
    - ptr ← (gnt_idx==NUM_REQ-1) ? 0 : gnt_idx+1.
    - Re-arbitrate in the same cycle using the updated ptr.
    - If a winner exists: load the new grant, hold_cnt=1, stay in GRANT (back-to-back, no idle bubble).
    - Otherwise: clear the grant and go to IDLE.
  - Otherwise: hold the grant and increment hold_cnt, which saturates at MAX_HOLD.
- timeout:
  - Pulses for one cycle, on the cycle after a revoke caused by hold_cnt==MAX_HOLD with done=0.
  - If done=1 on the same cycle, it is a normal release and timeout stays 0.
- A holder dropping req while granted does not end the grant; only done or timeout ends it.
- A re-arbitration after release may re-grant the same requester, but only when it is the only requester.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, ptr=0, hold_cnt=0, gnt_valid=0, gnt_onehot=0, gnt_idx=0, timeout=0.
- Request to grant: req sampled at edge N while IDLE → grant visible after edge N.
- Release to next grant: done sampled at edge N → new grant (or idle) visible after edge N. Zero bubble cycles.
- Forced revoke: the grant lasts exactly MAX_HOLD cycles.
- Reset mid-grant: outputs clear immediately and ptr returns to 0.
- All outputs are registered; there is no combinational path from req or done to any output.

## Structure
- Package rr_grant_pkg: state enum (IDLE, GRANT) and a wrap-increment function for ptr.
- Sub-module: priority_encoder, the existing lowest-index-first encoder with od_valid, one-hot od_filt and binary od_bin outputs.
  - Instantiate it twice: once on masked, once on req.
  - Select between them with the masked instance's od_valid.

## Test plan
- Reset: hold reset_n=0 with req=0xFF → gnt_valid=0, gnt_onehot=0x00, gnt_idx=0, timeout=0.
- Single request: req=0x01, done on the 3rd grant cycle → gnt_onehot=0x01, gnt_idx=0 after 1 edge; gnt_valid=0 after the done edge; ptr=1.
- Rotation:
  - Stimulus: req=0xFF held, done=1 every grant cycle.
  - Required response: gnt_idx sequence 0,1,2,…,7,0, one grant per cycle, no gaps.
- Fairness subset:
  - Stimulus: req=0x0C held, done every cycle.
  - Required response: gnt_idx alternates 2,3,2,3. Bits 0/1 are never granted.
- Timeout:
  - Stimulus: req=0x10, done=0.
  - Required response: gnt_idx=4 for exactly 16 cycles, then gnt_valid=0, timeout=1 for one cycle, ptr=5.
  - Follow-up: with req=0x11, the next grant is idx 0, because masked is empty and the controller wraps.
- Reset mid-grant: with a grant active on idx 3, pulse reset_n low between edges → outputs clear asynchronously. After release with req=0x0A, the first grant is idx 1, since ptr=0.
